// File: rtl/seq_11011_gen_pkg.sv
// Shared constants and state encoding for the 11011 burst generator.
// The pattern is stored MSB-first; bit index 0 of a burst is PATTERN[4].
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [4:0] PATTERN = 5'b11011;
    localparam int         PAT_LEN = 5;
    localparam int         REP_W   = 4;
    localparam int         IDX_W   = 3;

endpackage

// File: rtl/seq_11011_gen_if.sv
// Request/stream bundle between a burst requester (master) and the generator (slave).
// The generator's outputs are all registered; requests are sampled on the rising clock edge.
interface seq_11011_gen_if;
    import seq_pkg::*;

    logic             start;
    logic [REP_W-1:0] rep;
    logic             overlap;
    logic             abort;
    logic             dout;
    logic             dvalid;
    logic             busy;
    logic             done;
    logic             expect_det;

    modport master (
        output start, rep, overlap, abort,
        input  dout, dvalid, busy, done, expect_det
    );

    modport slave (
        input  start, rep, overlap, abort,
        output dout, dvalid, busy, done, expect_det
    );

endinterface

// File: rtl/seq_11011_gen.sv
// Serial generator emitting rep copies of 11011, either gap-separated or chained on the shared "11".
// Stream outputs trail the state register by one cycle, so the first bit appears two edges after start.
module seq_11011_gen
    import seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    seq_11011_gen_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAT_LEN - 1);
    localparam logic [IDX_W-1:0] CHAIN_IDX = IDX_W'(2);

    state_t           state;
    state_t           state_n;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_n;
    logic [REP_W-1:0] left;
    logic [REP_W-1:0] left_n;
    logic             ovl;
    logic             ovl_n;

    logic             dout_n;
    logic             dvalid_n;
    logic             busy_n;
    logic             done_n;
    logic             det_n;

    logic             accept;
    logic             cancel;
    logic             pat_end;

    // FIN behaves like IDLE for new requests, which lets bursts run back to back.
    assign accept  = bus.start && (bus.rep != '0) && ((state == IDLE) || (state == FIN));
    assign cancel  = bus.abort && ((state == SEND) || (state == GAP));
    assign pat_end = (state == SEND) && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
            left  <= '0;
            ovl   <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            left  <= left_n;
            ovl   <= ovl_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        left_n   = left;
        ovl_n    = ovl;
        dout_n   = 1'b0;
        dvalid_n = 1'b0;
        det_n    = 1'b0;
        done_n   = 1'b0;

        case (state)
            IDLE, FIN: begin
                done_n = (state == FIN);
                if (accept) begin
                    state_n = SEND;
                    idx_n   = '0;
                    left_n  = bus.rep;
                    ovl_n   = bus.overlap;
                end else begin
                    state_n = IDLE;
                end
            end

            SEND: begin
                dvalid_n = 1'b1;
                dout_n   = PATTERN[LAST_IDX - idx];
                det_n    = pat_end;
                if (pat_end) begin
                    if (left != REP_W'(1)) begin
                        left_n = left - REP_W'(1);
                        // A chained pattern reuses the trailing "11" as its prefix.
                        if (ovl) begin
                            idx_n = CHAIN_IDX;
                        end else begin
                            idx_n   = '0;
                            state_n = GAP;
                        end
                    end else begin
                        left_n  = '0;
                        idx_n   = '0;
                        state_n = FIN;
                    end
                end else begin
                    idx_n = idx + IDX_W'(1);
                end
            end

            GAP: begin
                dvalid_n = 1'b1;
                idx_n    = '0;
                state_n  = SEND;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Cancelling also suppresses the bit that would have been presented next.
        if (cancel) begin
            state_n  = IDLE;
            idx_n    = '0;
            left_n   = '0;
            dout_n   = 1'b0;
            dvalid_n = 1'b0;
            det_n    = 1'b0;
        end

        busy_n = (state_n == SEND) || (state_n == GAP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.dout       <= 1'b0;
            bus.dvalid     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.expect_det <= 1'b0;
        end else begin
            bus.dout       <= dout_n;
            bus.dvalid     <= dvalid_n;
            bus.busy       <= busy_n;
            bus.done       <= done_n;
            bus.expect_det <= det_n;
        end
    end

endmodule
